player_motion: RTL
==================

PLAYER_MOTION -- requirements
Module: player_motion

Interface
REQ-001 Parameters SHALL be: SIZE 16 (player sprite edge, px); SPEED 6 (px per frame tick); JUMP_V 12 (initial upward velocity); GRAVITY 1 (velocity change per tick); MAX_FALL 8 (fall velocity cap); MAP_LEN 4473 (map length, 7*639).
REQ-002 Ports, in order: Clk in 1, system clock; Reset in 1, asynchronous active-high reset.
REQ-003 frame_clk in 1: VGA frame clock, asynchronous to the update rate.
REQ-004 keycode in 8: held key; 8'd4 = A (left), 8'd7 = D (right), 8'd26 = W (jump), other values = idle.
REQ-005 DrawX, DrawY in 10: current VGA pixel.
REQ-006 start_X, start_Y in 10: spawn position, static.
REQ-007 can_move in 1: 1 = move sprite on screen; 0 = screen scrolls instead.
REQ-008 top, bot in 14: surface y-extent of the platform under player_location.
REQ-009 player_location out 14: player left edge in map coordinates.
REQ-010 player_X, player_Y out 10: sprite top-left on screen.
REQ-011 is_player out 1: DrawX/DrawY lies inside the sprite.
REQ-012 airborne out 1: 1 when the motion state is not GROUNDED.

Function
REQ-013 frame_clk SHALL be registered twice in Clk; tick = one-Clk pulse on the rising edge of the registered signal.
REQ-014 All position, velocity and state registers SHALL update only on tick; otherwise they hold.
REQ-015 Horizontal motion on tick, keycode A: player_location -= SPEED, saturating at 0.
REQ-016 On the same tick, if can_move = 1, player_X -= SPEED, saturating at 0; if can_move = 0, player_X holds.
REQ-017 Horizontal motion on tick, keycode D: player_location += SPEED, saturating at MAP_LEN-SIZE.
REQ-018 On the same tick, if can_move = 1, player_X += SPEED, saturating at 639-SIZE; if can_move = 0, player_X holds.
REQ-019 can_move and top SHALL be used as sampled on the tick; the one-tick lag from the platform block is accepted.
REQ-020 FSM states SHALL be GROUNDED, RISING and FALLING; velocity vel is an unsigned 5-bit value.
REQ-021 GROUNDED, first check: if top > player_Y+SIZE (ground dropped away), go to FALLING with vel = 0; this wins over W.
REQ-022 GROUNDED, otherwise: on W go to RISING with vel = JUMP_V; otherwise player_Y = top-SIZE (snap, covers step-ups).
REQ-023 RISING: player_Y -= vel, saturating at 0; then vel -= GRAVITY; when vel reaches 0, go to FALLING.
REQ-024 FALLING: vel = min(vel+GRAVITY, MAX_FALL); player_Y += vel.
REQ-025 FALLING landing: if the new player_Y+SIZE >= top, set player_Y = top-SIZE, vel = 0 and go to GROUNDED on the same tick.
REQ-026 W while RISING or FALLING SHALL be ignored (no double jump).
REQ-027 Vertical arithmetic SHALL be done at 14 bits and the result truncated to 10 bits only after clamping.
REQ-028 is_player SHALL be combinational: player_X <= DrawX < player_X+SIZE and player_Y <= DrawY < player_Y+SIZE.

Reset
REQ-029 Reset SHALL asynchronously set player_location = zero-extended start_X, player_X = start_X, player_Y = start_Y-SIZE.
REQ-030 Reset SHALL also set state = FALLING, vel = 0 and clear the edge-detect flops.
REQ-031 Reset asserted mid-jump SHALL abandon the jump immediately; the first tick after release settles via REQ-025.
REQ-032 Reset values of outputs: airborne = 1; is_player follows REQ-028 from the reset position.

Structure
REQ-033 A shared package player_pkg SHALL hold: the state enum, the keycode constants KEY_A, KEY_D and KEY_W, and the default values of SIZE, SPEED, JUMP_V, GRAVITY, MAX_FALL and MAP_LEN.
REQ-034 One sub-module, frame_tick, SHALL implement REQ-013 and be reusable by the platform block.

Verification
REQ-035 Reset with start_X = 100, start_Y = 300, top = 300; first tick -> player_Y = 284, GROUNDED, airborne = 0, player_location = 100.
REQ-036 D held 10 ticks, can_move = 1 -> player_X = 160, player_location = 160; repeat with can_move = 0 -> player_X stays 160, player_location = 220.
REQ-037 A from player_location = 4 -> player_location = 0, player_X saturates; no wrap to 16383.
REQ-038 W from GROUNDED at Y = 284 -> player_Y 272, 261, 251 ...; peak 206 after 12 ticks, then FALLING; lands on Y = 284, GROUNDED.
REQ-039 Grounded at top = 300, top changes to 400 -> FALLING next tick; lands at Y = 384; W pressed mid-fall is ignored.
REQ-040 Reset asserted mid-jump, released between ticks -> outputs return to the REQ-029/030 values; no tick is generated until the next frame_clk rising edge.

Source files
------------

// File: rtl/player_pkg.sv
// Shared types and defaults for the player motion block and its neighbours.
package player_pkg;

    typedef enum logic [1:0] {
        StGrounded,
        StRising,
        StFalling
    } motion_state_e;

    localparam logic [7:0] KEY_A = 8'd4;
    localparam logic [7:0] KEY_D = 8'd7;
    localparam logic [7:0] KEY_W = 8'd26;

    localparam int unsigned DEF_SIZE     = 16;
    localparam int unsigned DEF_SPEED    = 6;
    localparam int unsigned DEF_JUMP_V   = 12;
    localparam int unsigned DEF_GRAVITY  = 1;
    localparam int unsigned DEF_MAX_FALL = 8;
    localparam int unsigned DEF_MAP_LEN  = 4473;

    localparam int unsigned SCREEN_MAX_X = 639;

    // Clamp a 14-bit vertical result into the 10-bit screen range.
    function automatic logic [9:0] sat10(input logic [13:0] v);
        return (v > 14'd1023) ? 10'd1023 : v[9:0];
    endfunction

endpackage

// File: rtl/frame_tick.sv
// Brings the asynchronous VGA frame clock into Clk and emits a one-cycle tick per rising edge.
module frame_tick (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);

    logic sync_q;
    logic sync_prev_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync_q      <= 1'b0;
            sync_prev_q <= 1'b0;
        end else begin
            sync_q      <= frame_clk;
            sync_prev_q <= sync_q;
        end
    end

    assign tick = sync_q & ~sync_prev_q;

endmodule

// File: rtl/player_motion.sv
// Player position and jump/fall state machine, stepped once per frame tick.
module player_motion
    import player_pkg::*;
#(
    parameter int unsigned SIZE     = DEF_SIZE,
    parameter int unsigned SPEED    = DEF_SPEED,
    parameter int unsigned JUMP_V   = DEF_JUMP_V,
    parameter int unsigned GRAVITY  = DEF_GRAVITY,
    parameter int unsigned MAX_FALL = DEF_MAX_FALL,
    parameter int unsigned MAP_LEN  = DEF_MAP_LEN
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [7:0]  keycode,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  start_X,
    input  logic [9:0]  start_Y,
    input  logic        can_move,
    input  logic [13:0] top,
    input  logic [13:0] bot,
    output logic [13:0] player_location,
    output logic [9:0]  player_X,
    output logic [9:0]  player_Y,
    output logic        is_player,
    output logic        airborne
);

    localparam logic [13:0] SIZE14    = 14'(SIZE);
    localparam logic [9:0]  SIZE10    = 10'(SIZE);
    localparam logic [10:0] SIZE11    = 11'(SIZE);
    localparam logic [13:0] SPEED14   = 14'(SPEED);
    localparam logic [9:0]  SPEED10   = 10'(SPEED);
    localparam logic [13:0] LOC_MAX   = 14'(MAP_LEN - SIZE);
    localparam logic [9:0]  X_MAX     = 10'(SCREEN_MAX_X - SIZE);
    localparam logic [4:0]  JUMP_V5   = 5'(JUMP_V);
    localparam logic [4:0]  GRAVITY5  = 5'(GRAVITY);
    localparam logic [4:0]  MAX_FALL5 = 5'(MAX_FALL);

    logic tick;

    frame_tick u_frame_tick (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    motion_state_e state_q;
    logic [13:0]   loc_q;
    logic [9:0]    x_q;
    logic [9:0]    y_q;
    logic [4:0]    vel_q;

    // bot belongs to the platform interface; motion only needs the surface top.
    logic unused_bot;
    assign unused_bot = ^bot;

    logic is_left;
    logic is_right;
    logic is_jump;

    assign is_left  = (keycode == KEY_A);
    assign is_right = (keycode == KEY_D);
    assign is_jump  = (keycode == KEY_W);

    logic [13:0] loc_left;
    logic [13:0] loc_right;
    logic [9:0]  x_left;
    logic [9:0]  x_right;

    always_comb begin
        loc_left  = (loc_q < SPEED14) ? 14'd0 : loc_q - SPEED14;
        loc_right = (loc_q > LOC_MAX - SPEED14) ? LOC_MAX : loc_q + SPEED14;
        x_left    = (x_q < SPEED10) ? 10'd0 : x_q - SPEED10;
        x_right   = (x_q > X_MAX - SPEED10) ? X_MAX : x_q + SPEED10;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            loc_q <= {4'd0, start_X};
            x_q   <= start_X;
        end else if (tick) begin
            if (is_left) begin
                loc_q <= loc_left;
                if (can_move) begin
                    x_q <= x_left;
                end
            end else if (is_right) begin
                loc_q <= loc_right;
                if (can_move) begin
                    x_q <= x_right;
                end
            end
        end
    end

    logic [13:0] y_ext;
    logic [13:0] y_bottom;
    logic [9:0]  snap_y;
    logic [9:0]  rise_y;
    logic [4:0]  rise_vel;
    logic [5:0]  fall_sum;
    logic [4:0]  fall_vel;
    logic [13:0] fall_y;
    logic        fall_lands;
    logic [9:0]  reset_y;

    always_comb begin
        y_ext      = {4'd0, y_q};
        y_bottom   = y_ext + SIZE14;
        snap_y     = (top < SIZE14) ? 10'd0 : sat10(top - SIZE14);
        rise_y     = (y_q < {5'd0, vel_q}) ? 10'd0 : y_q - {5'd0, vel_q};
        rise_vel   = (vel_q < GRAVITY5) ? 5'd0 : vel_q - GRAVITY5;
        fall_sum   = {1'b0, vel_q} + {1'b0, GRAVITY5};
        fall_vel   = (fall_sum > {1'b0, MAX_FALL5}) ? MAX_FALL5 : fall_sum[4:0];
        fall_y     = y_ext + {9'd0, fall_vel};
        fall_lands = (fall_y + SIZE14) >= top;
        reset_y    = (start_Y < SIZE10) ? 10'd0 : start_Y - SIZE10;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StFalling;
            vel_q   <= 5'd0;
            y_q     <= reset_y;
        end else if (tick) begin
            unique case (state_q)
                StGrounded: begin
                    // Losing the ground beneath us takes priority over a jump request.
                    if (top > y_bottom) begin
                        state_q <= StFalling;
                        vel_q   <= 5'd0;
                    end else if (is_jump) begin
                        state_q <= StRising;
                        vel_q   <= JUMP_V5;
                    end else begin
                        y_q <= snap_y;
                    end
                end
                StRising: begin
                    y_q   <= rise_y;
                    vel_q <= rise_vel;
                    if (rise_vel == 5'd0) begin
                        state_q <= StFalling;
                    end
                end
                StFalling: begin
                    if (fall_lands) begin
                        y_q     <= snap_y;
                        vel_q   <= 5'd0;
                        state_q <= StGrounded;
                    end else begin
                        y_q   <= sat10(fall_y);
                        vel_q <= fall_vel;
                    end
                end
                default: begin
                    state_q <= StFalling;
                    vel_q   <= 5'd0;
                end
            endcase
        end
    end

    assign player_location = loc_q;
    assign player_X        = x_q;
    assign player_Y        = y_q;
    assign airborne        = (state_q != StGrounded);

    always_comb begin
        is_player = ({1'b0, DrawX} >= {1'b0, x_q}) && ({1'b0, DrawX} < {1'b0, x_q} + SIZE11) &&
                    ({1'b0, DrawY} >= {1'b0, y_q}) && ({1'b0, DrawY} < {1'b0, y_q} + SIZE11);
    end

endmodule
